// File: rtl/handshake_arbiter.sv
// Round-robin merge of CH_AMOUNT req/ack channels onto one return-to-zero slave handshake.
// Define HANDSHAKE_ARBITER_TIMEOUT_EN to build in the stalled-transaction watchdog.
//
// state | meaning
// IDLE  | s_req_o low; grants the next candidate at the following edge
// REQ   | s_req_o high for channel s_ch_o; waits for s_ack_i (or the watchdog)
module handshake_arbiter #(
  parameter int CH_AMOUNT      = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TIMEOUT_W      = 16,
  localparam int CH_W          = $clog2(CH_AMOUNT)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [CH_AMOUNT-1:0] m_req_i,
  output logic [CH_AMOUNT-1:0] m_ack_o,
  output logic [CH_AMOUNT-1:0] m_err_o,
  output logic                 s_req_o,
  output logic [CH_W-1:0]      s_ch_o,
  input  logic                 s_ack_i
);

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_e;

  state_e               state_q, state_d;
  logic [CH_AMOUNT-1:0] pending_q, pending_d;
  logic [CH_W-1:0]      last_q, last_d;
  logic [CH_W-1:0]      s_ch_q, s_ch_d;
  logic                 s_req_q, s_req_d;
  logic [CH_AMOUNT-1:0] m_ack_q, m_ack_d;

  logic [CH_AMOUNT-1:0] cand;
  logic [CH_AMOUNT-1:0] served;
  logic                 grant_vld;
  logic [CH_W-1:0]      grant_idx;
  logic                 timeout;
  logic                 done;

`ifdef HANDSHAKE_ARBITER_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic [CH_AMOUNT-1:0] m_err_q, m_err_d;

  // Counter sits at zero in IDLE, so it is already cleared on entry to REQ.
  always_comb begin
    cnt_d = '0;
    if (state_q == REQ) cnt_d = cnt_q + TIMEOUT_W'(1);
  end

  assign timeout = (state_q == REQ) && !s_ack_i &&
                   (cnt_q == TIMEOUT_W'(TIMEOUT_CYCLES - 1));
  assign m_err_o = m_err_q;
`else
  assign timeout = 1'b0;
  assign m_err_o = '0;
`endif

  assign done = (state_q == REQ) && (s_ack_i || timeout);

  // Round-robin search starting just after the previously served channel.
  always_comb begin
    cand      = pending_q | m_req_i;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < CH_AMOUNT; i++) begin
      logic [CH_W-1:0] idx;
      idx = CH_W'((int'(last_q) + 1 + i) % CH_AMOUNT);
      if (!grant_vld && cand[idx]) begin
        grant_vld = 1'b1;
        grant_idx = idx;
      end
    end
  end

  always_comb begin
    served = '0;
    if (done) served[s_ch_q] = 1'b1;
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      pending_q <= '0;
      last_q    <= CH_W'(CH_AMOUNT - 1);
      s_ch_q    <= '0;
      s_req_q   <= 1'b0;
      m_ack_q   <= '0;
`ifdef HANDSHAKE_ARBITER_TIMEOUT_EN
      cnt_q     <= '0;
      m_err_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      last_q    <= last_d;
      s_ch_q    <= s_ch_d;
      s_req_q   <= s_req_d;
      m_ack_q   <= m_ack_d;
`ifdef HANDSHAKE_ARBITER_TIMEOUT_EN
      cnt_q     <= cnt_d;
      m_err_q   <= m_err_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_vld) state_d = REQ;
      REQ:     if (done)      state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Output and datapath next values; every output is registered.
  always_comb begin
    pending_d = (pending_q & ~served) | (m_req_i & ~pending_q);
    last_d    = last_q;
    s_ch_d    = s_ch_q;
    s_req_d   = s_req_q;
    m_ack_d   = '0;
`ifdef HANDSHAKE_ARBITER_TIMEOUT_EN
    m_err_d   = '0;
`endif
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          s_req_d = 1'b1;
          s_ch_d  = grant_idx;
        end
      end
      REQ: begin
        if (done) begin
          s_req_d = 1'b0;
          last_d  = s_ch_q;
          if (s_ack_i) m_ack_d = served;
`ifdef HANDSHAKE_ARBITER_TIMEOUT_EN
          else         m_err_d = served;
`endif
        end
      end
      default: s_req_d = 1'b0;
    endcase
  end

  assign s_req_o = s_req_q;
  assign s_ch_o  = s_ch_q;
  assign m_ack_o = m_ack_q;

endmodule
